// File: rtl/wimpfi_frame_xmit.sv
// Buffers a terminal byte stream, defers to the carrier with binary-exponential backoff, then sends preamble/SFD/header/payload/CRC-8.
// Latency: first tx byte the cycle after backoff ends; following bytes back-to-back; frame_sent one cycle after CRC acceptance.
// Backpressure: tx_byte held while tx_ready=0; in_ready=0 from the frame-closing byte until back in IDLE.
module wimpfi_frame_xmit #(
    parameter int         MAX_LEN      = 255,
    parameter int         PRE_LEN      = 2,
    parameter logic [7:0] TERM_CHAR    = 8'h04,
    parameter int         SLOT_CYCLES  = 1000,
    parameter int         MAX_ATTEMPTS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] src_addr,
    input  logic [7:0] packet_type,
    input  logic       cardet,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_en,
    output logic       frame_sent,
    output logic       frame_drop,
    output logic [7:0] xerrcnt
);
    localparam int NW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int PW = 10;
    localparam logic [PW-1:0] POS_SFD  = PW'(PRE_LEN);
    localparam logic [PW-1:0] POS_DST  = PW'(PRE_LEN + 1);
    localparam logic [PW-1:0] POS_SRC  = PW'(PRE_LEN + 2);
    localparam logic [PW-1:0] POS_TYPE = PW'(PRE_LEN + 3);
    localparam logic [PW-1:0] POS_PAY  = PW'(PRE_LEN + 4);
    localparam logic [7:0]    ATT_LAST = 8'(MAX_ATTEMPTS - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, DEFER, BACKOFF, SEND} state_t;

    state_t         state_q, state_d;
    logic [NW-1:0]  n_q, n_d;
    logic [3:0]     k_q, k_d;
    logic [7:0]     att_q, att_d;
    logic [7:0]     dst_q, dst_d, src_q, src_d, type_q, type_d;
    logic [7:0]     bo_q, bo_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic [AW-1:0]  raddr_q, raddr_d;
    logic [7:0]     crc_q, crc_d;
    logic           is_crc_q, is_crc_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic           tx_valid_q, tx_valid_d, tx_en_q, tx_en_d;
    logic           sent_q, sent_d, drop_q, drop_d;
    logic [7:0]     xerr_q, xerr_d;
    logic           in_ready_q, in_ready_d;
    logic [7:0]     lfsr_q, lfsr_d;
    logic [7:0]     mem_q [0:MAX_LEN-1];
    logic [7:0]     rdata_q;
    logic           wr_en, accept, close;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     nxt, mask;
    logic [PW-1:0]  pay_end;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign accept  = in_valid && in_ready_q;
    assign wr_addr = n_q[AW-1:0];
    assign mask    = 8'hFF >> (4'd8 - k_q);
    assign pay_end = POS_PAY + {{(PW-NW){1'b0}}, n_q};
    assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Next-state logic: collection, carrier deferral/backoff and byte sequencing.
    always_comb begin
        state_d = state_q;  n_d = n_q;  k_d = k_q;  att_d = att_q;
        dst_d = dst_q;  src_d = src_q;  type_d = type_q;
        bo_d = bo_q;  cyc_d = cyc_q;  pos_d = pos_q;  raddr_d = raddr_q;
        crc_d = crc_q;  is_crc_d = is_crc_q;
        tx_byte_d = tx_byte_q;  tx_valid_d = tx_valid_q;  tx_en_d = tx_en_q;
        sent_d = 1'b0;  drop_d = 1'b0;  xerr_d = xerr_q;
        wr_en = 1'b0;  close = 1'b0;  nxt = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (accept && in_data != TERM_CHAR) begin
                    dst_d   = in_data;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (in_data == TERM_CHAR) begin
                        close = 1'b1;
                    end else if (n_q < NW'(MAX_LEN)) begin
                        wr_en = 1'b1;
                        n_d   = n_q + NW'(1);
                        if (n_q == NW'(MAX_LEN - 1)) close = 1'b1;
                    end else begin
                        // Buffer already full: drop the byte and record it.
                        xerr_d = (xerr_q == 8'hFF) ? xerr_q : xerr_q + 8'd1;
                    end
                end
                if (close) begin
                    src_d   = src_addr;
                    type_d  = packet_type;
                    state_d = DEFER;
                end
            end
            DEFER: begin
                if (!cardet) begin
                    bo_d    = lfsr_q & mask;
                    cyc_d   = '0;
                    state_d = BACKOFF;
                end
            end
            BACKOFF: begin
                // Carrier has priority over slot expiry in the same cycle.
                if (cardet) begin
                    if (att_q >= ATT_LAST) begin
                        drop_d  = 1'b1;
                        xerr_d  = (xerr_q == 8'hFF) ? xerr_q : xerr_q + 8'd1;
                        n_d     = '0;
                        k_d     = 4'd1;
                        att_d   = '0;
                        state_d = IDLE;
                    end else begin
                        att_d   = att_q + 8'd1;
                        k_d     = (k_q == 4'd8) ? k_q : k_q + 4'd1;
                        state_d = DEFER;
                    end
                end else if (bo_q == 8'd0) begin
                    tx_byte_d  = 8'h55;
                    tx_valid_d = 1'b1;
                    tx_en_d    = 1'b1;
                    pos_d      = PW'(1);
                    raddr_d    = '0;
                    crc_d      = 8'h00;
                    is_crc_d   = 1'b0;
                    state_d    = SEND;
                end else if (cyc_q == CW'(SLOT_CYCLES - 1)) begin
                    cyc_d = '0;
                    bo_d  = bo_q - 8'd1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (is_crc_q) begin
                        tx_valid_d = 1'b0;
                        tx_en_d    = 1'b0;
                        tx_byte_d  = 8'h00;
                        sent_d     = 1'b1;
                        n_d        = '0;
                        k_d        = 4'd1;
                        att_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        pos_d = pos_q + PW'(1);
                        if (pos_q < POS_SFD)        nxt = 8'h55;
                        else if (pos_q == POS_SFD)  nxt = 8'hD0;
                        else if (pos_q == POS_DST)  nxt = dst_q;
                        else if (pos_q == POS_SRC)  nxt = src_q;
                        else if (pos_q == POS_TYPE) nxt = type_q;
                        else if (pos_q < pay_end) begin
                            // rdata_q already holds this byte; move the prefetch on.
                            nxt     = rdata_q;
                            raddr_d = (raddr_q == AW'(MAX_LEN - 1)) ? raddr_q : raddr_q + AW'(1);
                        end else begin
                            nxt      = crc_q;
                            is_crc_d = 1'b1;
                        end
                        tx_byte_d = nxt;
                        if (pos_q > POS_SFD && pos_q < pay_end) crc_d = crc8_step(crc_q, nxt);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_q == IDLE || state_q == COLLECT) &&
                     (state_d == IDLE || state_d == COLLECT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;  n_q <= '0;  k_q <= 4'd1;  att_q <= '0;
            dst_q <= '0;  src_q <= '0;  type_q <= '0;
            bo_q <= '0;  cyc_q <= '0;  pos_q <= '0;  raddr_q <= '0;
            crc_q <= '0;  is_crc_q <= 1'b0;
            tx_byte_q <= 8'h00;  tx_valid_q <= 1'b0;  tx_en_q <= 1'b0;
            sent_q <= 1'b0;  drop_q <= 1'b0;  xerr_q <= 8'h00;
            in_ready_q <= 1'b0;  lfsr_q <= 8'h01;
        end else begin
            state_q <= state_d;  n_q <= n_d;  k_q <= k_d;  att_q <= att_d;
            dst_q <= dst_d;  src_q <= src_d;  type_q <= type_d;
            bo_q <= bo_d;  cyc_q <= cyc_d;  pos_q <= pos_d;  raddr_q <= raddr_d;
            crc_q <= crc_d;  is_crc_q <= is_crc_d;
            tx_byte_q <= tx_byte_d;  tx_valid_q <= tx_valid_d;  tx_en_q <= tx_en_d;
            sent_q <= sent_d;  drop_q <= drop_d;  xerr_q <= xerr_d;
            in_ready_q <= in_ready_d;  lfsr_q <= lfsr_d;
        end
    end

    // Payload RAM; read address uses the next pointer so data is ready one cycle early.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= in_data;
        rdata_q <= mem_q[raddr_d];
    end

    assign in_ready   = in_ready_q;
    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign tx_en      = tx_en_q;
    assign frame_sent = sent_q;
    assign frame_drop = drop_q;
    assign xerrcnt    = xerr_q;
endmodule

// File: tb/tb_wimpfi_frame_xmit.sv
// Bench for wimpfi_frame_xmit: directed frames, tx_ready throttling, MAX_LEN auto-close,
// mid-frame reset, carrier-busy drops and xerrcnt saturation; tx bytes scoreboarded.
// Stimulus pushes expected wire bytes; a negedge monitor pops on every tx handshake.
module tb_wimpfi_frame_xmit;
    localparam int         MAX_LEN      = 4;
    localparam int         PRE_LEN      = 2;
    localparam logic [7:0] TERM         = 8'h04;
    localparam int         SLOT_CYCLES  = 4;
    localparam int         MAX_ATTEMPTS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] src_addr = 8'h00;
    logic [7:0] packet_type = 8'h00;
    logic       cardet;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_en;
    logic       frame_sent;
    logic       frame_drop;
    logic [7:0] xerrcnt;

    wimpfi_frame_xmit #(
        .MAX_LEN(MAX_LEN), .PRE_LEN(PRE_LEN), .TERM_CHAR(TERM),
        .SLOT_CYCLES(SLOT_CYCLES), .MAX_ATTEMPTS(MAX_ATTEMPTS)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .src_addr(src_addr), .packet_type(packet_type), .cardet(cardet),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_en(tx_en),
        .frame_sent(frame_sent), .frame_drop(frame_drop), .xerrcnt(xerrcnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         sent_cnt = 0;
    int         drop_cnt = 0;
    bit         throttle = 1'b0;
    bit         toggle = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial CRC-8 (poly 07, init 00, MSB first).
    function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] b);
        logic fb;
        for (int j = 7; j >= 0; j--) begin
            fb = c[7] ^ b[j];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] d, input logic [7:0] s, input logic [7:0] t,
                              input logic [31:0] pl, input int n);
        logic [7:0] c;
        logic [7:0] b;
        for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD0);
        exp_q.push_back(d); exp_q.push_back(s); exp_q.push_back(t);
        c = crc_bits(8'h00, d);
        c = crc_bits(c, s);
        c = crc_bits(c, t);
        for (int i = 0; i < n; i++) begin
            b = pl[31-8*i -: 8];
            exp_q.push_back(b);
            c = crc_bits(c, b);
        end
        exp_q.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        in_data = b; in_valid = 1'b1;
        while (!ok && n < 3000) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("in_byte_accepted", ok, 1);
    endtask

    task automatic send_seq(input logic [7:0] d, input logic [31:0] pl, input int n, input bit term);
        send_byte(d);
        for (int i = 0; i < n; i++) send_byte(pl[31-8*i -: 8]);
        if (term) send_byte(TERM);
        check("in_ready_low_after_close", in_ready, 0);
    endtask

    task automatic wait_sent(input int target);
        int n;
        n = 0;
        while (sent_cnt < target && n < 3000) begin @(posedge clk); n++; end
        #1;
        check("frame_sent_count", sent_cnt, target);
    endtask

    task automatic wait_drop(input int target);
        int n;
        n = 0;
        while (drop_cnt < target && n < 3000) begin @(posedge clk); n++; end
        #1;
        check("frame_drop_count", drop_cnt, target);
    endtask

    // Carrier: idle, or toggling every cycle so every backoff sees a busy carrier.
    initial begin
        cardet = 1'b0;
        forever begin
            @(posedge clk); #1;
            cardet = toggle ? ~cardet : 1'b0;
        end
    end

    // Transmitter ready: always, or stalled about 30% of cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = throttle ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold-while-stalled, tx_en framing, pulse counts.
    initial begin
        logic       pv, pr, pen;
        logic [7:0] pb;
        pv = 1'b0; pr = 1'b0; pen = 1'b0; pb = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pen = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("tx_valid_held", tx_valid, 1);
                    check("tx_byte_held", tx_byte, pb);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tx_unexpected: byte %0h, expected none", tx_byte);
                    end else begin
                        check("tx_byte", tx_byte, exp_q.pop_front());
                    end
                end
                if (tx_valid) check("tx_en_with_valid", tx_en, 1);
                if (frame_sent) begin
                    sent_cnt++;
                    check("tx_en_low_at_sent", tx_en, 0);
                end
                if (pen && !tx_en) check("tx_en_falls_with_sent", frame_sent, 1);
                if (frame_drop) drop_cnt++;
                pv = tx_valid; pr = tx_ready; pb = tx_byte; pen = tx_en;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_frame_sent", frame_sent, 0);
        check("rst_frame_drop", frame_drop, 0);
        check("rst_xerrcnt", xerrcnt, 8'h00);
        rst = 1'b0;
        @(negedge clk); check("in_ready_before_first_edge", in_ready, 0);
        @(negedge clk); check("in_ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Basic frame with idle carrier.
        src_addr = 8'h11; packet_type = 8'h30;
        push_frame(8'h22, 8'h11, 8'h30, 32'h4142_0000, 2);
        send_seq(8'h22, 32'h4142_0000, 2, 1'b1);
        wait_sent(1);

        // Same frame under tx_ready throttling.
        throttle = 1'b1;
        push_frame(8'h22, 8'h11, 8'h30, 32'h4142_0000, 2);
        send_seq(8'h22, 32'h4142_0000, 2, 1'b1);
        wait_sent(2);
        throttle = 1'b0;

        // MAX_LEN auto-close; the extra byte becomes the next header-only frame's dst.
        src_addr = 8'hA5; packet_type = 8'h5A;
        push_frame(8'h33, 8'hA5, 8'h5A, 32'h0102_0305, 4);
        send_seq(8'h33, 32'h0102_0305, 4, 1'b0);
        push_frame(8'h77, 8'hA5, 8'h5A, 32'h0, 0);
        send_seq(8'h77, 32'h0, 0, 1'b1);
        wait_sent(4);

        // Reset while the payload of a frame is on the wire.
        src_addr = 8'h11; packet_type = 8'h30;
        push_frame(8'h66, 8'h11, 8'h30, 32'h5051_0000, 2);
        send_seq(8'h66, 32'h5051_0000, 2, 1'b1);
        n = 0;
        while (!(tx_valid && tx_byte == 8'h50) && n < 3000) begin @(negedge clk); n++; end
        check("reached_payload", (tx_valid && tx_byte == 8'h50), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_tx_byte", tx_byte, 8'h00);
        check("mid_rst_frame_sent", frame_sent, 0);
        check("mid_rst_frame_drop", frame_drop, 0);
        check("mid_rst_xerrcnt", xerrcnt, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("in_ready_after_mid_rst", in_ready, 1);
        repeat (30) @(posedge clk);
        #1;
        check("no_frame_after_rst", sent_cnt, 4);
        check("no_drop_after_rst", drop_cnt, 0);

        // Carrier busy at every backoff: frame dropped after MAX_ATTEMPTS.
        toggle = 1'b1;
        send_seq(8'h44, 32'h0, 0, 1'b1);
        wait_drop(1);
        check("xerrcnt_first_drop", xerrcnt, 8'h01);
        repeat (2) @(negedge clk);
        check("in_ready_after_drop", in_ready, 1);
        @(posedge clk); #1;

        // Drive the error count to saturation and beyond.
        for (int i = 2; i <= 257; i++) begin
            send_byte(8'h44);
            send_byte(TERM);
            wait_drop(i);
            if (i == 256) check("xerrcnt_at_256", xerrcnt, 8'hFF);
        end
        check("xerrcnt_saturated", xerrcnt, 8'hFF);
        toggle = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sent_total", sent_cnt, 4);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
